// File: rtl/uart_ram_bridge_if.sv
// UART byte stream and RAM controller signals of uart_ram_bridge.
// master = bridge side, slave = UART core / RAM controller side.
interface uart_ram_bridge_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        mem_en;
   logic        mem_re;
   logic        mem_we;
   logic [17:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   modport master (
      input  rx_valid, rx_data, tx_busy, mem_rdata,
      output tx_start, tx_data, mem_en, mem_re, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_valid, rx_data, tx_busy, mem_rdata,
      input  tx_start, tx_data, mem_en, mem_re, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/uart_ram_bridge.sv
// UART command frames ('W'/'R') to timed RAM controller accesses, with byte replies.
// Optional: define UART_RAM_BRIDGE_AUTOINC_EN for the 'N' write-to-next-address command.
module uart_ram_bridge #(
   parameter int WR_CYCLES = 4,
   parameter int RD_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   uart_ram_bridge_if.master   bus,
   output logic                busy,
   output logic                rx_overrun
);

   typedef enum logic [3:0] {IDLE, A0, A1, A2, D0, D1, MWR, MRD, TXH, TXL, TXW} state_t;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK    = 8'h4B;
`ifdef UART_RAM_BRIDGE_AUTOINC_EN
   localparam logic [7:0] CMD_AI = 8'h4E;
`endif

   state_t     state, next;
   logic [7:0] cnt;
   logic [7:0] rd_lo;
   logic       is_wr;
   logic       more;
   logic       seen;
   logic       mem_last;
   logic       rx_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      mem_last = (state == MWR && cnt == 8'(WR_CYCLES - 1)) ||
                 (state == MRD && cnt == 8'(RD_CYCLES - 1));
   end

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      next = state;
      unique case (state)
         IDLE: begin
            if (bus.rx_valid && (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)) next = A0;
`ifdef UART_RAM_BRIDGE_AUTOINC_EN
            else if (bus.rx_valid && bus.rx_data == CMD_AI) next = D0;
`endif
         end
         A0:      if (bus.rx_valid) next = A1;
         A1:      if (bus.rx_valid) next = A2;
         A2:      if (bus.rx_valid) next = is_wr ? D0 : MRD;
         D0:      if (bus.rx_valid) next = D1;
         D1:      if (bus.rx_valid) next = MWR;
         MWR:     if (mem_last) next = TXL;
         MRD:     if (mem_last) next = TXH;
         TXH,
         TXL:     if (!bus.tx_busy) next = TXW;
         TXW:     if (seen && !bus.tx_busy) next = more ? TXL : IDLE;
         default: next = IDLE;
      endcase
   end

   // Strobes decode straight from state so an asynchronous reset drops mem_we/mem_re at once.
   always_comb begin
      bus.mem_we   = (state == MWR);
      bus.mem_re   = (state == MRD);
      bus.mem_en   = !(state == MWR || state == MRD);
      bus.tx_start = (state == TXH || state == TXL) && !bus.tx_busy;
      busy         = (state != IDLE);
      rx_drop      = bus.rx_valid && (state inside {MWR, MRD, TXH, TXL, TXW});
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         rd_lo         <= '0;
         is_wr         <= 1'b0;
         more          <= 1'b0;
         seen          <= 1'b0;
         rx_overrun    <= 1'b0;
         bus.tx_data   <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         cnt <= ((state == MWR || state == MRD) && !mem_last) ? cnt + 8'd1 : 8'd0;

         if (rx_drop) rx_overrun <= 1'b1;

         if (state == IDLE && bus.rx_valid) is_wr <= (bus.rx_data == CMD_WR);

`ifdef UART_RAM_BRIDGE_AUTOINC_EN
         // Frames cannot be abandoned short of reset, so mem_addr in IDLE is the last-used address.
         if (state == IDLE && bus.rx_valid && bus.rx_data == CMD_AI)
            bus.mem_addr <= bus.mem_addr + 18'd1;
`endif

         if (bus.rx_valid) begin
            unique case (state)
               A0:      bus.mem_addr[17:16] <= bus.rx_data[1:0];
               A1:      bus.mem_addr[15:8]  <= bus.rx_data;
               A2:      bus.mem_addr[7:0]   <= bus.rx_data;
               D0:      bus.mem_wdata[15:8] <= bus.rx_data;
               D1:      bus.mem_wdata[7:0]  <= bus.rx_data;
               default: ;
            endcase
         end

         if (state == MWR && mem_last) bus.tx_data <= ACK;
         if (state == MRD && mem_last) begin
            bus.tx_data <= bus.mem_rdata[15:8];
            rd_lo       <= bus.mem_rdata[7:0];
         end

         // The transmitter latches tx_data on tx_start, so the low byte can be staged right away.
         if (bus.tx_start) begin
            seen <= 1'b0;
            more <= (state == TXH);
            if (state == TXH) bus.tx_data <= rd_lo;
         end else if (state == TXW && bus.tx_busy) begin
            seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Directed self-checking bench for uart_ram_bridge with a simple UART transmitter responder.
module tb_uart_ram_bridge;
   localparam int WR = 4;
   localparam int RD = 4;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic rx_overrun;

   uart_ram_bridge_if bus ();

   uart_ram_bridge #(.WR_CYCLES(WR), .RD_CYCLES(RD)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .rx_overrun (rx_overrun)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          proto_err = 0;
   int          we_cnt, re_cnt;
   logic [17:0] we_addr, re_addr;
   logic [15:0] we_data;
   logic        prev_we = 1'b0;
   logic        prev_re = 1'b0;
   logic [7:0]  tx_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Transmitter: busy for three clocks after each accepted tx_start.
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            tx_q.push_back(bus.tx_data);
            @(posedge clk);
            #1 bus.tx_busy = 1'b1;
            repeat (3) @(posedge clk);
            #1 bus.tx_busy = 1'b0;
         end
      end
   end

   // Bus monitor: strobe lengths, captured address/data, and protocol rules.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.mem_we && bus.mem_re) proto_err++;
            if (bus.mem_en !== !(bus.mem_we || bus.mem_re)) proto_err++;
            if (bus.tx_start && bus.tx_busy) proto_err++;
            if (bus.mem_we) begin
               if (!prev_we) begin
                  we_addr = bus.mem_addr;
                  we_data = bus.mem_wdata;
               end else if (bus.mem_addr !== we_addr || bus.mem_wdata !== we_data) proto_err++;
               we_cnt++;
            end else if (prev_we && (bus.mem_addr !== we_addr || bus.mem_wdata !== we_data)) begin
               proto_err++;
            end
            if (bus.mem_re) begin
               if (!prev_re) re_addr = bus.mem_addr;
               else if (bus.mem_addr !== re_addr) proto_err++;
               re_cnt++;
            end
         end
         prev_we = bus.mem_we;
         prev_re = bus.mem_re;
      end
   end

   task automatic clear_mon();
      we_cnt  = 0;
      re_cnt  = 0;
      we_addr = 18'h2AAAA;
      re_addr = 18'h2AAAA;
      we_data = 16'h5555;
      tx_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 32'(n < 1000), 32'd1);
   endtask

   initial begin
      bus.rx_valid  = 1'b0;
      bus.rx_data   = 8'h00;
      bus.mem_rdata = 16'h0000;
      rst = 1'b1;
      clear_mon();
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_start",  bus.tx_start,  0);
      check("rst_tx_data",   bus.tx_data,   0);
      check("rst_mem_en",    bus.mem_en,    1);
      check("rst_mem_re",    bus.mem_re,    0);
      check("rst_mem_we",    bus.mem_we,    0);
      check("rst_mem_addr",  bus.mem_addr,  0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_busy",      busy,          0);
      check("rst_overrun",   rx_overrun,    0);
      @(negedge clk);
      rst = 1'b0;

      // Write 57 00 12 34 AB CD
      clear_mon();
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h12);
      send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
      check("wr_latency", bus.mem_we, 1);
      wait_idle("wr_idle_timeout");
      check("wr_we_cycles", we_cnt,       WR);
      check("wr_addr",      we_addr,      18'h01234);
      check("wr_data",      we_data,      16'hABCD);
      check("wr_re_cycles", re_cnt,       0);
      check("wr_tx_count",  tx_q.size(),  1);
      check("wr_ack",       tx_q[0],      8'h4B);

      // Read 52 03 FF FF with rdata 5A3C
      clear_mon();
      bus.mem_rdata = 16'h5A3C;
      send_byte(8'h52); send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF);
      check("rd_latency", bus.mem_re, 1);
      wait_idle("rd_idle_timeout");
      check("rd_re_cycles", re_cnt,      RD);
      check("rd_addr",      re_addr,     18'h3FFFF);
      check("rd_tx_count",  tx_q.size(), 2);
      check("rd_hi",        tx_q[0],     8'h5A);
      check("rd_lo",        tx_q[1],     8'h3C);

      // Unknown byte, then a read; upper bits of the first address byte are ignored
      clear_mon();
      bus.mem_rdata = 16'h1234;
      send_byte(8'h00);
      check("unk_busy", busy, 0);
      send_byte(8'h52); send_byte(8'hFC); send_byte(8'h00); send_byte(8'h05);
      wait_idle("unk_idle_timeout");
      check("unk_re_cycles", re_cnt,      RD);
      check("unk_addr",      re_addr,     18'h00005);
      check("unk_tx_count",  tx_q.size(), 2);
      check("unk_hi",        tx_q[0],     8'h12);
      check("unk_lo",        tx_q[1],     8'h34);
      check("unk_overrun",   rx_overrun,  0);

      // Byte 0x41 arriving during MRD
      clear_mon();
      bus.mem_rdata = 16'hA55A;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h41);
      check("ovr_flag", rx_overrun, 1);
      wait_idle("ovr_idle_timeout");
      check("ovr_re_cycles", re_cnt,      RD);
      check("ovr_addr",      re_addr,     18'h00100);
      check("ovr_tx_count",  tx_q.size(), 2);
      check("ovr_hi",        tx_q[0],     8'hA5);
      check("ovr_lo",        tx_q[1],     8'h5A);
      check("ovr_sticky",    rx_overrun,  1);

`ifdef UART_RAM_BRIDGE_AUTOINC_EN
      // Write to 0x3FFFF, then 'N' wraps to 0x00000
      clear_mon();
      send_byte(8'h57); send_byte(8'h03); send_byte(8'hFF);
      send_byte(8'hFF); send_byte(8'h00); send_byte(8'h01);
      wait_idle("ai_first_timeout");
      check("ai_first_addr", we_addr, 18'h3FFFF);
      clear_mon();
      send_byte(8'h4E); send_byte(8'h11); send_byte(8'h22);
      check("ai_latency", bus.mem_we, 1);
      wait_idle("ai_idle_timeout");
      check("ai_we_cycles", we_cnt,      WR);
      check("ai_addr",      we_addr,     18'h00000);
      check("ai_data",      we_data,     16'h1122);
      check("ai_tx_count",  tx_q.size(), 1);
      check("ai_ack",       tx_q[0],     8'h4B);
`else
      // 'N' is an unknown command here; 11 and 22 are discarded as well
      clear_mon();
      send_byte(8'h4E); send_byte(8'h11); send_byte(8'h22);
      repeat (10) @(posedge clk);
      #1;
      check("n_busy",      busy,        0);
      check("n_we_cycles", we_cnt,      0);
      check("n_tx_count",  tx_q.size(), 0);
`endif

      // Reset during the second clock of MWR
      clear_mon();
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h00); send_byte(8'h77);
      check("rstw_latency", bus.mem_we, 1);
      @(posedge clk);
      #1;
      check("rstw_we_2nd", bus.mem_we, 1);
      rst = 1'b1;
      #1;
      check("rstw_we",      bus.mem_we, 0);
      check("rstw_en",      bus.mem_en, 1);
      check("rstw_busy",    busy,       0);
      check("rstw_overrun", rx_overrun, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("rstw_no_ack", tx_q.size(), 0);

      clear_mon();
      bus.mem_rdata = 16'hC381;
      send_byte(8'h52); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
      wait_idle("post_idle_timeout");
      check("post_re_cycles", re_cnt,      RD);
      check("post_addr",      re_addr,     18'h2ABCD);
      check("post_tx_count",  tx_q.size(), 2);
      check("post_hi",        tx_q[0],     8'hC3);
      check("post_lo",        tx_q[1],     8'h81);

      check("protocol_errors", proto_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_ram_bridge.md
UART_RAM_BRIDGE -- requirements
Module: uart_ram_bridge

Interface
REQ-001 Parameter WR_CYCLES, default 4: clocks that mem_we is held high per write (legal range 2..255).
REQ-002 Parameter RD_CYCLES, default 4: clocks that mem_re is held high per read (legal range 2..255).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 rx_valid  in  1  one-cycle strobe, received UART byte on rx_data.
REQ-006 rx_data  in  8  received byte.
REQ-007 tx_busy  in  1  UART transmitter busy.
REQ-008 tx_start  out  1  one-cycle strobe, load tx_data into transmitter.
REQ-009 tx_data  out  8  byte to transmit.
REQ-010 mem_en  out  1  RAM controller enable, active-low (1 = idle).
REQ-011 mem_re, mem_we  out  1 each  read / write request to RAM controller.
REQ-012 mem_addr  out  18  word address.
REQ-013 mem_wdata  out  16  write data.
REQ-014 mem_rdata  in  16  read data from RAM controller.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 rx_overrun  out  1  sticky flag: a received byte was dropped.

Function
REQ-017 Frame format: command byte, then 3 address bytes MSB first (bits 7:2 of the first address byte ignored), then for writes 2 data bytes MSB first.
REQ-018 Commands: 0x57 'W' = write, 0x52 'R' = read; any other byte in IDLE is discarded and the state stays IDLE.
REQ-019 States: IDLE, A0, A1, A2, D0, D1, MWR, MRD, TXH, TXL, TXW; advance A0->A1->A2->(D0->D1 for write) on each rx_valid only.
REQ-020 MWR: mem_en=0, mem_we=1 for exactly WR_CYCLES clocks, with mem_addr/mem_wdata stable from the first clock through one clock after mem_we falls; then send ack byte 0x4B.
REQ-021 MRD: mem_en=0, mem_re=1 for exactly RD_CYCLES clocks; mem_rdata is captured on the last such clock; then transmit the high byte, then the low byte.
REQ-022 TX handshake: tx_start pulses one clock only while tx_busy=0; the next byte waits until tx_busy has been seen high and then low again (TXW).
REQ-023 mem_re and mem_we are never high simultaneously; mem_en=1 whenever both are low.
REQ-024 rx_valid arriving in MWR, MRD, TXH, TXL or TXW: byte dropped, rx_overrun set to 1 until reset.
REQ-025 Last-byte-to-mem-request latency: mem_we or mem_re rises on the clock after the final frame byte is accepted.

Reset
REQ-026 On rst: state IDLE; tx_start=0, tx_data=0, mem_en=1, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, rx_overrun=0, internal counters=0.
REQ-027 rst asserted mid-access terminates the access immediately (mem_we/mem_re low asynchronously); the partial frame is discarded.

Configuration
REQ-028 Macro UART_RAM_BRIDGE_AUTOINC_EN defined: command 0x4E 'N' takes 2 data bytes only and writes to last-used address + 1, wrapping 0x3FFFF -> 0x00000; last-used address is 0 after reset.
REQ-029 Macro undefined: 0x4E is treated as an unknown command and discarded; no increment logic is present.

Verification
REQ-030 Write: bytes 57 00 12 34 AB CD -> mem_addr=0x01234, mem_wdata=0xABCD, mem_we high exactly 4 clocks, then tx byte 0x4B.
REQ-031 Read: bytes 52 03 FF FF with mem_rdata=0x5A3C -> mem_re high 4 clocks at address 0x3FFFF; tx bytes 0x5A then 0x3C, each with a single tx_start.
REQ-032 Unknown byte 0x00 then a valid read frame -> 0x00 ignored, read executes normally, rx_overrun stays 0.
REQ-033 Byte 0x41 sent during MRD -> byte dropped, rx_overrun=1, read response unaffected.
REQ-034 AUTOINC_EN: write frame to 0x3FFFF, then bytes 4E 11 22 -> second write to 0x00000 with data 0x1122.
REQ-035 rst pulsed during the 2nd clock of MWR -> mem_we=0 and mem_en=1 immediately, busy=0, next frame processed normally.
